// File: rtl/digit_fifo.sv
// Circular digit FIFO feeding the sequence detector; idle code 4'hF when dry.
// Optional BCD filtering on push: define DIGIT_FIFO_BCD_CHECK_EN.
module digit_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_digit,
  input  logic              rd_en,
  output logic [3:0]        number,
  output logic              number_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              bad_digit
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W+1)'(DEPTH);

  logic [3:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [3:0]        num_q, num_d;
  logic              val_q, val_d;
  logic              ovf_q, ovf_d;
  logic              wr_bad;
  logic              pop;
  logic              push;

`ifdef DIGIT_FIFO_BCD_CHECK_EN
  logic bad_q, bad_d;

  assign wr_bad = wr_en && (wr_digit > 4'd9);
  assign bad_d  = bad_q | wr_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bad_q <= 1'b0;
    else       bad_q <= bad_d;
  end

  assign bad_digit = bad_q;
`else
  assign wr_bad    = 1'b0;
  assign bad_digit = 1'b0;
`endif

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
  assign pop  = rd_en && !empty_q;
  assign push = wr_en && !wr_bad && (!full_q || pop);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    val_d   = 1'b0;
    ovf_d   = ovf_q;
    if (wr_en && !wr_bad && !push) ovf_d = 1'b1;
    if (push) wp_d = wp_q + ADDR_W'(1);
    if (pop) begin
      rp_d  = rp_q + ADDR_W'(1);
      num_d = mem_q[rp_q];
      val_d = 1'b1;
    end else if (rd_en) begin
      num_d = 4'hF;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == FullCnt);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      num_q   <= 4'hF;
      val_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      num_q   <= num_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q] <= wr_digit;
  end

  assign number       = num_q;
  assign number_valid = val_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_digit_fifo.sv
// Directed bench for digit_fifo: queue scoreboard of stored digits,
// checked with immediate assertions after every clock edge.
module tb_digit_fifo;

`ifdef DIGIT_FIFO_BCD_CHECK_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_digit;
  logic       rd_en;
  logic [3:0] number;
  logic       number_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       bad_digit;

  int checks = 0;
  int errors = 0;

  logic [3:0] q[$];
  logic [3:0] e_num;
  logic       e_val;
  logic       e_ovf;
  logic       e_bad;

  digit_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_digit(wr_digit),
    .rd_en(rd_en),
    .number(number),
    .number_valid(number_valid),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .bad_digit(bad_digit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".number"}, {4'h0, number}, {4'h0, e_num});
    chk({tag, ".valid"}, {7'h0, number_valid}, {7'h0, e_val});
    chk({tag, ".count"}, {4'h0, count}, 8'(q.size()));
    chk({tag, ".full"}, {7'h0, full}, {7'h0, q.size() == 8});
    chk({tag, ".empty"}, {7'h0, empty}, {7'h0, q.size() == 0});
    chk({tag, ".overflow"}, {7'h0, overflow}, {7'h0, e_ovf});
    chk({tag, ".bad_digit"}, {7'h0, bad_digit}, {7'h0, e_bad});
  endtask

  task automatic model_reset();
    q.delete();
    e_num = 4'hF;
    e_val = 1'b0;
    e_ovf = 1'b0;
    e_bad = 1'b0;
  endtask

  task automatic step(input string tag, input logic w,
                      input logic [3:0] d, input logic r);
    bit pop, bad, acc;
    @(negedge clock);
    wr_en    = w;
    wr_digit = d;
    rd_en    = r;
    pop = r && (q.size() > 0);
    bad = BCD && (d > 4'd9);
    acc = w && !bad && ((q.size() < 8) || pop);
    if (w && !bad && !acc) e_ovf = 1'b1;
    if (w && bad) e_bad = 1'b1;
    if (pop) begin
      e_num = q.pop_front();
      e_val = 1'b1;
    end else begin
      if (r) e_num = 4'hF;
      e_val = 1'b0;
    end
    if (acc) q.push_back(d);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clock);
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_digit = 4'h0;
    rd_en    = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #12;
    reset = 1'b0;

    // 1,0,9,4 streamed straight through
    step("seq1", 1'b1, 4'd1, 1'b1);
    step("seq0", 1'b1, 4'd0, 1'b1);
    step("seq9", 1'b1, 4'd9, 1'b1);
    step("seq4", 1'b1, 4'd4, 1'b1);
    step("seq_t", 1'b0, 4'd0, 1'b1);
    step("seq_i", 1'b0, 4'd0, 1'b1);
    step("seq_h", 1'b0, 4'd0, 1'b0);

    // fill, push+pop while full, overflow, drain
    async_reset("rst_fill");
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 4'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) step("full_rw", 1'b1, 4'd5, 1'b1);
    step("ovf", 1'b1, 4'd7, 1'b0);
    step("ovf_hold", 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) step("drain", 1'b0, 4'd0, 1'b1);

    // pointer wrap with occupancy held in 3..6
    async_reset("rst_wrap");
    for (int i = 0; i < 3; i++) step("wfill", 1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 12; i++)
      step("wrap", 1'b1, 4'((i + 3) % 10),
           (q.size() >= 5) || ((i % 2 == 1) && (q.size() >= 4)));
    for (int i = 0; i < 8; i++) step("wdrain", 1'b0, 4'd0, 1'b1);

    // non-BCD digits
    step("hexB", 1'b1, 4'hB, 1'b0);
    step("hexF", 1'b1, 4'hF, 1'b0);
    step("hex3", 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++) step("hexpop", 1'b0, 4'd0, 1'b1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) step("pre", 1'b1, 4'(i + 2), 1'b0);
    async_reset("rst_mid");
    step("post7", 1'b1, 4'd7, 1'b1);
    step("post_out", 1'b0, 4'd0, 1'b1);
    step("post_idle", 1'b0, 4'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_fifo.md
# digit_fifo

Buffered digit source placed directly upstream of the `sequence_detector`. It accepts 4-bit decimal digits from a producer (keypad decoder, UART digit parser) at an irregular rate and stores them in a small circular FIFO. It drives the detector's `number` input with one stored digit per paced clock. When no digit is available it drives the idle code 4'hF, which never matches a sequence element and returns the detector to its start state.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 3: pointer width; must equal log2(`DEPTH`).

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: push request for `wr_digit` this cycle.
- `wr_digit`  in  4: digit to push.
- `rd_en`  in  1: advance the output stream this cycle.
- `number`  out  4: registered digit to the detector; 4'hF when idle.
- `number_valid`  out  1: `number` carries a FIFO digit popped at the last edge.
- `full`  out  1: occupancy == `DEPTH`.
- `empty`  out  1: occupancy == 0.
- `count`  out  `ADDR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow`  out  1: sticky; a push was dropped because the FIFO was full.
- `bad_digit`  out  1: sticky; a non-BCD digit was dropped. Driven 0 when the macro is absent.

## Operation
- Storage is `DEPTH` x 4-bit memory with write pointer `wp`, read pointer `rp` and occupancy counter `count`. Both pointers wrap modulo `DEPTH`.
- Push is accepted when `wr_en`=1 and either `full`=0, or `full`=1 with a pop in the same cycle. An accepted push writes `mem[wp]` and increments `wp`.
- Push attempted when `full`=1 and no pop this cycle: digit dropped, `overflow`<=1, pointers unchanged.
- Pop occurs when `rd_en`=1 and `empty`=0:
  - `number`<=`mem[rp]`, `number_valid`<=1, `rp` increments.
- `rd_en`=1 and `empty`=1: `number`<=4'hF, `number_valid`<=0.
- `rd_en`=0: `number` holds its value, `number_valid`<=0, no pop.
- There is no write-to-read bypass. A digit pushed into an empty FIFO is not poppable on the same edge.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `full` and `empty` are registered, updated together with `count`.
- `overflow` and `bad_digit` clear only on `reset`.
- Reset (asynchronous, takes effect mid-operation):
  - `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0.
  - `number`=4'hF, `number_valid`=0, `overflow`=0, `bad_digit`=0.
  - Memory contents are not cleared and are unreachable after reset.

## Timing
- Write-to-output latency: push at edge k into an empty FIFO with `rd_en`=1 gives `number`=digit after edge k+1.
- The detector samples that value at edge k+2.
- Sustained throughput is one digit per cycle with `wr_en`=`rd_en`=1 continuously. Digits come out in write order with no idle codes between them.
- Simultaneous push and pop when full: both occur, `count` stays `DEPTH`, `full` stays 1, `overflow` unchanged.
- Simultaneous push and pop when `count`=1: both occur, `count` stays 1.
- Status outputs (`full`, `empty`, `count`) reflect state after the most recent edge.

## Configuration
- `DIGIT_FIFO_BCD_CHECK_EN` defined:
  - A push with `wr_digit` > 9 is dropped and `bad_digit`<=1.
  - This check takes precedence over the full check, so `overflow` is not set for such a push.
- Undefined: every digit 0..15 is stored and emitted unchanged, and `bad_digit` is tied to 0.
- Undefined, stored 4'hF: it is emitted with `number_valid`=1.

## Test plan
- Push 1,0,9,4 on consecutive edges with `rd_en`=1 -> `number` shows 1,0,9,4 after the following four edges, each with `number_valid`=1, then 4'hF with `number_valid`=0. A detector attached to `number` pulses `out` once.
- With `rd_en`=0, push 8 digits -> `full`=1, `count`=8. Push a 9th -> `overflow`=1, `count`=8. Set `rd_en`=1 -> the first 8 digits come out in order, then `empty`=1.
- FIFO full, `wr_en`=`rd_en`=1 with digit 5 for 3 cycles -> `count` stays 8, `overflow`=0. Later output includes three 5s after the original contents.
- Pointer wrap: 12 pushes interleaved with pops, occupancy kept between 3 and 6 -> output order equals input order across the wrap, `count` correct every cycle.
- Push 4'hB:
  - Macro defined -> dropped, `bad_digit`=1, `count` unchanged.
  - Macro undefined -> stored, and `number`=4'hB with `number_valid`=1 on its pop.
- Assert `reset` between edges with `count`=4 -> outputs go to reset values immediately, without a clock edge. After release, push 7 -> `number`=7 one edge later.
